// File: rtl/multi_cycle_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path: opcodes, FSM states, ALU/mux codes.
// No logic beyond small opcode-classification helpers.
package multi_cycle_pkg;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_ADDIU = 6'b000010;
   localparam logic [5:0] OP_AND   = 6'b010000;
   localparam logic [5:0] OP_ORI   = 6'b010010;
   localparam logic [5:0] OP_SLL   = 6'b011000;
   localparam logic [5:0] OP_SLT   = 6'b100110;
   localparam logic [5:0] OP_SW    = 6'b110000;
   localparam logic [5:0] OP_LW    = 6'b110001;
   localparam logic [5:0] OP_BEQ   = 6'b110100;
   localparam logic [5:0] OP_BNE   = 6'b110101;
   localparam logic [5:0] OP_J     = 6'b111000;
   localparam logic [5:0] OP_JR    = 6'b111001;
   localparam logic [5:0] OP_JAL   = 6'b111010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   typedef enum logic [3:0] {
      S_IF    = 4'd0,
      S_ID    = 4'd1,
      S_EXE_R = 4'd2,
      S_WB_R  = 4'd3,
      S_EXE_B = 4'd4,
      S_EXE_M = 4'd5,
      S_MEM   = 4'd6,
      S_WB_L  = 4'd7,
      S_HLT   = 4'd8
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_SLL = 3'b010,
      ALU_OR  = 3'b011,
      ALU_AND = 3'b100,
      ALU_SLT = 3'b101
   } alu_op_t;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_RS  = 2'b10;
   localparam logic [1:0] PC_JMP = 2'b11;

   localparam logic [1:0] REG_RA = 2'b00;
   localparam logic [1:0] REG_RT = 2'b01;
   localparam logic [1:0] REG_RD = 2'b10;

   typedef struct packed {
      logic       pc_wre;
      logic       ir_wre;
      logic       reg_wre;
      logic       m_rd;
      logic       m_wr;
      logic       alu_src_a;
      logic       alu_src_b;
      logic       db_data_src;
      logic       wr_reg_d_src;
      logic       ext_sel;
      logic [1:0] reg_dst;
      logic [1:0] pc_src;
      alu_op_t    alu_op;
      logic       halted;
   } ctrl_t;

   function automatic logic is_alu_op(input logic [5:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDIU) || (op == OP_AND) ||
             (op == OP_ORI) || (op == OP_SLL) || (op == OP_SLT);
   endfunction

   function automatic logic uses_imm(input logic [5:0] op);
      return (op == OP_ADDIU) || (op == OP_ORI);
   endfunction

   function automatic alu_op_t alu_op_of(input logic [5:0] op);
      alu_op_t r;
      case (op)
         OP_SUB:  r = ALU_SUB;
         OP_AND:  r = ALU_AND;
         OP_ORI:  r = ALU_OR;
         OP_SLL:  r = ALU_SLL;
         OP_SLT:  r = ALU_SLT;
         default: r = ALU_ADD;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// Controller <-> datapath bundle: opcode/zero from the datapath, enables and mux selects back to it.
// master = control sequencer, slave = datapath.
interface multi_cycle_control_if;

   logic [5:0] opcode;
   logic       zero;
   logic       PCWre;
   logic       IRWre;
   logic       RegWre;
   logic       mRD;
   logic       mWR;
   logic       ALUSrcA;
   logic       ALUSrcB;
   logic       DBDataSrc;
   logic       WrRegDSrc;
   logic       ExtSel;
   logic [1:0] RegDst;
   logic [1:0] PCSrc;
   logic [2:0] ALUOp;
   logic       halted;

   modport master (
      input  opcode, zero,
      output PCWre, IRWre, RegWre, mRD, mWR, ALUSrcA, ALUSrcB, DBDataSrc,
             WrRegDSrc, ExtSel, RegDst, PCSrc, ALUOp, halted
   );

   modport slave (
      output opcode, zero,
      input  PCWre, IRWre, RegWre, mRD, mWR, ALUSrcA, ALUSrcB, DBDataSrc,
             WrRegDSrc, ExtSel, RegDst, PCSrc, ALUOp, halted
   );

endinterface

// File: rtl/multi_cycle_decode.sv
// Purely combinational (state, opcode, zero) -> control word and next state; zero latency, no backpressure.
// Selects are driven 0 outside the state that uses them so the datapath never sees X.
module multi_cycle_decode
   import multi_cycle_pkg::*;
(
   input  state_t     state_i,
   input  logic [5:0] opcode_i,
   input  logic       zero_i,
   output ctrl_t      ctrl_o,
   output state_t     state_d_o
);

   always_comb begin
      ctrl_o    = '0;
      state_d_o = S_IF;

      case (state_i)
         S_IF: begin
            ctrl_o.ir_wre = 1'b1;
            state_d_o     = S_ID;
         end

         S_ID: begin
            case (opcode_i)
               OP_J: begin
                  ctrl_o.pc_wre = 1'b1;
                  ctrl_o.pc_src = PC_JMP;
               end
               OP_JAL: begin
                  // Link register is written from PC+4 in the same cycle the PC jumps.
                  ctrl_o.pc_wre       = 1'b1;
                  ctrl_o.pc_src       = PC_JMP;
                  ctrl_o.reg_wre      = 1'b1;
                  ctrl_o.reg_dst      = REG_RA;
                  ctrl_o.wr_reg_d_src = 1'b0;
               end
               OP_JR: begin
                  ctrl_o.pc_wre = 1'b1;
                  ctrl_o.pc_src = PC_RS;
               end
               OP_HALT: state_d_o = S_HLT;
               OP_BEQ, OP_BNE: state_d_o = S_EXE_B;
               OP_SW, OP_LW:   state_d_o = S_EXE_M;
               default: begin
                  if (is_alu_op(opcode_i)) begin
                     state_d_o = S_EXE_R;
                  end else begin
                     ctrl_o.pc_wre = 1'b1;
                  end
               end
            endcase
         end

         S_EXE_R: begin
            ctrl_o.alu_op    = alu_op_of(opcode_i);
            ctrl_o.alu_src_a = (opcode_i == OP_SLL);
            ctrl_o.alu_src_b = uses_imm(opcode_i);
            ctrl_o.ext_sel   = (opcode_i != OP_ORI);
            state_d_o        = S_WB_R;
         end

         S_WB_R: begin
            ctrl_o.reg_wre      = 1'b1;
            ctrl_o.wr_reg_d_src = 1'b1;
            ctrl_o.reg_dst      = uses_imm(opcode_i) ? REG_RT : REG_RD;
            ctrl_o.pc_wre       = 1'b1;
         end

         S_EXE_B: begin
            ctrl_o.alu_op  = ALU_SUB;
            ctrl_o.ext_sel = 1'b1;
            ctrl_o.pc_wre  = 1'b1;
            if (((opcode_i == OP_BEQ) && zero_i) || ((opcode_i == OP_BNE) && !zero_i)) begin
               ctrl_o.pc_src = PC_BR;
            end
         end

         S_EXE_M: begin
            ctrl_o.alu_op    = ALU_ADD;
            ctrl_o.alu_src_b = 1'b1;
            ctrl_o.ext_sel   = 1'b1;
            state_d_o        = S_MEM;
         end

         S_MEM: begin
            if (opcode_i == OP_LW) begin
               ctrl_o.m_rd = 1'b1;
               state_d_o   = S_WB_L;
            end else begin
               ctrl_o.m_wr   = 1'b1;
               ctrl_o.pc_wre = 1'b1;
            end
         end

         S_WB_L: begin
            ctrl_o.reg_wre      = 1'b1;
            ctrl_o.db_data_src  = 1'b1;
            ctrl_o.wr_reg_d_src = 1'b1;
            ctrl_o.reg_dst      = REG_RT;
            ctrl_o.pc_wre       = 1'b1;
         end

         S_HLT: begin
            ctrl_o.halted = 1'b1;
            state_d_o     = S_HLT;
         end

         default: state_d_o = S_IF;
      endcase
   end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU control sequencer: state register plus decode; outputs combinational, no backpressure.
// Optional MCC_PERF_CNT_EN adds cycle_cnt / instr_cnt performance counters.
module multi_cycle_control
   import multi_cycle_pkg::*;
(
   input  logic                  CLK,
   input  logic                  Reset,
   multi_cycle_control_if.master ctl
`ifdef MCC_PERF_CNT_EN
   ,
   output logic [31:0]           cycle_cnt,
   output logic [31:0]           instr_cnt
`endif
);

   state_t state_q;
   state_t state_d;
   ctrl_t  ctrl;
   ctrl_t  ctrl_out;

   multi_cycle_decode u_decode (
      .state_i   (state_q),
      .opcode_i  (ctl.opcode),
      .zero_i    (ctl.zero),
      .ctrl_o    (ctrl),
      .state_d_o (state_d)
   );

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IF;
      end else begin
         state_q <= state_d;
      end
   end

   // Reset also gates the strobes combinationally, so a mid-instruction reset kills writes at once.
   always_comb begin
      ctrl_out = ctrl;
      if (!Reset) begin
         ctrl_out.pc_wre  = 1'b0;
         ctrl_out.ir_wre  = 1'b0;
         ctrl_out.reg_wre = 1'b0;
         ctrl_out.m_rd    = 1'b0;
         ctrl_out.m_wr    = 1'b0;
         ctrl_out.halted  = 1'b0;
      end
   end

   assign ctl.PCWre     = ctrl_out.pc_wre;
   assign ctl.IRWre     = ctrl_out.ir_wre;
   assign ctl.RegWre    = ctrl_out.reg_wre;
   assign ctl.mRD       = ctrl_out.m_rd;
   assign ctl.mWR       = ctrl_out.m_wr;
   assign ctl.ALUSrcA   = ctrl_out.alu_src_a;
   assign ctl.ALUSrcB   = ctrl_out.alu_src_b;
   assign ctl.DBDataSrc = ctrl_out.db_data_src;
   assign ctl.WrRegDSrc = ctrl_out.wr_reg_d_src;
   assign ctl.ExtSel    = ctrl_out.ext_sel;
   assign ctl.RegDst    = ctrl_out.reg_dst;
   assign ctl.PCSrc     = ctrl_out.pc_src;
   assign ctl.ALUOp     = ctrl_out.alu_op;
   assign ctl.halted    = ctrl_out.halted;

`ifdef MCC_PERF_CNT_EN
   logic [31:0] cycle_cnt_q;
   logic [31:0] instr_cnt_q;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
      end else begin
         if (state_q != S_HLT) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
         end
         if (ctrl_out.pc_wre) begin
            instr_cnt_q <= instr_cnt_q + 32'd1;
         end
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
// Instruction-level reference model of the control sequencer, checked every cycle plus directed literals.
module tb_multi_cycle_control;

   typedef struct packed {
      logic       pcwre, irwre, regwre, mrd, mwr, srca, srcb, dbsrc, wrsrc, ext;
      logic [1:0] regdst, pcsrc;
      logic [2:0] aluop;
      logic       halted;
   } out_t;

   localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDIU = 6'b000010, AND_ = 6'b010000,
                          ORI = 6'b010010, SLL = 6'b011000, SLT = 6'b100110, SW = 6'b110000,
                          LW = 6'b110001, BEQ = 6'b110100, BNE = 6'b110101, J = 6'b111000,
                          JR = 6'b111001, JAL = 6'b111010, HALT = 6'b111111;

   logic CLK = 1'b0;
   logic Reset;
   always #5 CLK = ~CLK;

   multi_cycle_control_if bus ();
`ifdef MCC_PERF_CNT_EN
   logic [31:0] cycle_cnt, instr_cnt;
`endif

   multi_cycle_control dut (
      .CLK   (CLK),
      .Reset (Reset),
      .ctl   (bus)
`ifdef MCC_PERF_CNT_EN
      ,
      .cycle_cnt (cycle_cnt),
      .instr_cnt (instr_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;
   logic [5:0] cur_op = 6'b0;
   int cur_k = 0;
   out_t trace [0:63];

   // 1 alu, 2 branch, 3 memory, 4 jump, 5 halt, 0 anything else (NOP)
   function automatic int cls(input logic [5:0] op);
      case (op)
         ADD, SUB, ADDIU, AND_, ORI, SLL, SLT: return 1;
         BEQ, BNE:                             return 2;
         SW, LW:                               return 3;
         J, JR, JAL:                           return 4;
         HALT:                                 return 5;
         default:                              return 0;
      endcase
   endfunction

   function automatic int lat(input logic [5:0] op);
      case (cls(op))
         1:       return 4;
         2:       return 3;
         3:       return (op == LW) ? 5 : 4;
         5:       return 1000000;
         default: return 2;
      endcase
   endfunction

   // Expected outputs in cycle k of an instruction (k=0 is its fetch cycle).
   function automatic out_t model(input logic [5:0] op, input int k, input logic z, input logic rst);
      out_t e = '0;
      int c = cls(op);
      if (!rst) return e;
      if (k == 0) begin
         e.irwre = 1'b1;
         return e;
      end
      if (k == lat(op) - 1) e.pcwre = 1'b1;
      case (c)
         1: begin
            if (k == 2) begin
               case (op)
                  SUB:     e.aluop = 3'b001;
                  SLL:     e.aluop = 3'b010;
                  ORI:     e.aluop = 3'b011;
                  AND_:    e.aluop = 3'b100;
                  SLT:     e.aluop = 3'b101;
                  default: e.aluop = 3'b000;
               endcase
               e.srca = (op == SLL);
               e.srcb = (op == ADDIU) || (op == ORI);
               e.ext  = (op != ORI);
            end
            if (k == 3) begin
               e.regwre = 1'b1;
               e.wrsrc  = 1'b1;
               e.regdst = ((op == ADDIU) || (op == ORI)) ? 2'b01 : 2'b10;
            end
         end
         2: if (k == 2) begin
            e.aluop = 3'b001;
            e.ext   = 1'b1;
            if ((op == BEQ && z) || (op == BNE && !z)) e.pcsrc = 2'b01;
         end
         3: begin
            if (k == 2) begin
               e.srcb = 1'b1;
               e.ext  = 1'b1;
            end
            if (k == 3) begin
               if (op == LW) e.mrd = 1'b1;
               else          e.mwr = 1'b1;
            end
            if (k == 4) begin
               e.regwre = 1'b1;
               e.dbsrc  = 1'b1;
               e.wrsrc  = 1'b1;
               e.regdst = 2'b01;
            end
         end
         4: if (k == 1) begin
            e.pcsrc = (op == JR) ? 2'b10 : 2'b11;
            if (op == JAL) e.regwre = 1'b1;
         end
         5: if (k >= 2) e.halted = 1'b1;
         default: ;
      endcase
      return e;
   endfunction

   function automatic out_t observe();
      out_t o;
      o.pcwre = bus.PCWre;   o.irwre = bus.IRWre;     o.regwre = bus.RegWre;
      o.mrd   = bus.mRD;     o.mwr   = bus.mWR;       o.srca   = bus.ALUSrcA;
      o.srcb  = bus.ALUSrcB; o.dbsrc = bus.DBDataSrc; o.wrsrc  = bus.WrRegDSrc;
      o.ext   = bus.ExtSel;  o.regdst = bus.RegDst;   o.pcsrc  = bus.PCSrc;
      o.aluop = bus.ALUOp;   o.halted = bus.halted;
      return o;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Per-cycle compare, including a counter model driven by the expected outputs.
   initial begin
      int unsigned m_cyc = 0, m_ins = 0;
      logic prev_rst = 1'b0, prev_halt = 1'b0, prev_pcw = 1'b0;
      out_t e;
      forever begin
         @(negedge CLK);
         #1;
         if (!Reset) begin
            m_cyc = 0;
            m_ins = 0;
         end else if (prev_rst) begin
            m_cyc += prev_halt ? 0 : 1;
            m_ins += prev_pcw ? 1 : 0;
         end
         e = model(cur_op, cur_k, bus.zero, Reset);
         chk($sformatf("cycle op=%b k=%0d", cur_op, cur_k), {12'b0, observe()}, {12'b0, e});
`ifdef MCC_PERF_CNT_EN
         chk("cycle_cnt", cycle_cnt, m_cyc);
         chk("instr_cnt", instr_cnt, m_ins);
`endif
         prev_rst  = Reset;
         prev_halt = e.halted;
         prev_pcw  = e.pcwre;
      end
   end

   task automatic set_cyc(input logic [5:0] op, input int k, input int zsel);
      if (k == 0) bus.opcode = op;
      cur_op   = op;
      cur_k    = k;
      bus.zero = (zsel == 2) ? 1'($urandom % 2) : 1'(zsel);
      #1;
      if (k < 64) trace[k] = observe();
   endtask

   task automatic next_edge();
      @(posedge CLK);
      #1;
   endtask

   task automatic run_instr(input logic [5:0] op, input int zsel);
      for (int k = 0; k < lat(op); k++) begin
         set_cyc(op, k, zsel);
         next_edge();
      end
   endtask

   initial begin
      logic [5:0] op;
      logic [5:0] table_ops [14];
      table_ops = '{ADD, SUB, ADDIU, AND_, ORI, SLL, SLT, SW, LW, BEQ, BNE, J, JR, JAL};

      Reset = 1'b0;
      bus.opcode = 6'b0;
      bus.zero = 1'b0;
      #20;
      chk("rst_irwre", bus.IRWre, 0);
      #10;
      Reset = 1'b1;

      run_instr(ADD, 2);
      chk("add_ir_k0", trace[0].irwre, 1);
      chk("add_pcw_k2", trace[2].pcwre, 0);
      chk("add_regwre_wb", trace[3].regwre, 1);
      chk("add_regdst_wb", trace[3].regdst, 2'b10);
      chk("add_pcw_wb", trace[3].pcwre, 1);
      run_instr(LW, 2);
      chk("lw_mrd", trace[3].mrd, 1);
      chk("lw_dbsrc", trace[4].dbsrc, 1);
      chk("lw_regwre", trace[4].regwre, 1);
      run_instr(J, 2);
`ifdef MCC_PERF_CNT_EN
      chk("lit_instr_cnt", instr_cnt, 3);
      chk("lit_cycle_cnt", cycle_cnt, 11);
`endif
      run_instr(SW, 2);
      chk("sw_mwr", trace[3].mwr, 1);
      chk("sw_pcw", trace[3].pcwre, 1);
      run_instr(BEQ, 1);
      chk("beq_z1", trace[2].pcsrc, 2'b01);
      run_instr(BEQ, 0);
      chk("beq_z0", trace[2].pcsrc, 2'b00);
      run_instr(BNE, 0);
      chk("bne_z0", trace[2].pcsrc, 2'b01);
      run_instr(BNE, 1);
      chk("bne_z1", trace[2].pcsrc, 2'b00);
      run_instr(JAL, 2);
      chk("jal_ctl", {trace[1].regwre, trace[1].regdst, trace[1].wrsrc, trace[1].pcsrc, trace[1].pcwre},
          7'b1_00_0_11_1);
      run_instr(JR, 2);
      chk("jr_pcsrc", trace[1].pcsrc, 2'b10);
      run_instr(6'b101010, 2);
      chk("nop_pcw", {trace[1].pcwre, trace[1].regwre}, 2'b10);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(3) != 0) op = table_ops[$urandom_range(13)];
         else                        op = 6'($urandom);
         if (op == HALT) op = ADD;
         run_instr(op, 2);
      end

      // Reset arriving while SW is in its memory-write cycle.
      for (int k = 0; k < 4; k++) begin
         set_cyc(SW, k, 2);
         if (k < 3) next_edge();
      end
      chk("sw_mem_mwr", trace[3].mwr, 1);
      @(negedge CLK);
      #2;
      Reset = 1'b0;
      #1;
      chk("rst_mid_mwr", bus.mWR, 0);
      next_edge();
      next_edge();
      @(negedge CLK);
      Reset = 1'b1;
      run_instr(ADD, 2);
      chk("post_rst_ir", trace[0].irwre, 1);

      for (int k = 0; k < 52; k++) begin
         set_cyc(HALT, k, 2);
         next_edge();
      end
      chk("hlt_on", trace[2].halted, 1);
      chk("hlt_idle", {trace[51].pcwre, trace[51].irwre, trace[51].regwre, trace[51].mrd,
                       trace[51].mwr, trace[51].halted}, 6'b000001);
      Reset = 1'b0;
      #1;
      chk("hlt_rst", bus.halted, 0);
      next_edge();
      @(negedge CLK);
      Reset = 1'b1;
      run_instr(SUB, 2);
      chk("after_hlt_ir", trace[0].irwre, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Control sequencer for the multi-cycle MIPS-subset CPU. It walks each instruction through IF/ID/EXE/MEM/WB states, decoding the 6-bit opcode latched in the datapath's instruction register. It drives every datapath enable and mux select, so the shared ALU, register file and data memory are each used in a different cycle of one instruction. It is instantiated alongside the datapath inside the CPU top level.

## Interface
- No parameters; opcode, state and ALU codes come from the package.
- `CLK` in 1: system clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26]; stable from ID until the next IF.
- `zero` in 1: ALU zero flag; combinational in the same cycle.
- `PCWre` out 1: PC write enable.
- `IRWre` out 1: IR write enable.
- `RegWre` out 1: register-file write enable.
- `mRD`, `mWR` out 1 each: data-memory read and write strobes.
- `ALUSrcA` out 1: 1 selects shamt.
- `ALUSrcB` out 1: 1 selects the extended immediate.
- `DBDataSrc` out 1: 1 selects memory data for writeback.
- `WrRegDSrc` out 1: 0 selects PC+4 for JAL.
- `ExtSel` out 1: 1 = sign-extend, 0 = zero-extend.
- `RegDst` out 2: 00 = $31, 01 = rt, 10 = rd.
- `PCSrc` out 2: 00 = PC+4, 01 = branch target, 10 = rs, 11 = jump target.
- `ALUOp` out 3: 000 add, 001 sub, 010 sll, 011 or, 100 and, 101 slt.
- `halted` out 1: high in HLT.

## Operation
- Opcodes:
  - Arithmetic/logic: ADD 000000, SUB 000001, ADDIU 000010, AND 010000, ORI 010010, SLL 011000, SLT 100110.
  - Memory: SW 110000, LW 110001.
  - Branch: BEQ 110100, BNE 110101.
  - Jump/stop: J 111000, JR 111001, JAL 111010, HALT 111111.
- States (4-bit): IF, ID, EXE_R, WB_R, EXE_B, EXE_M, MEM, WB_L, HLT.
- Transitions:
  - IF→ID, always.
  - ID→IF for J/JR/JAL/illegal; ID→HLT for HALT.
  - ID→EXE_R for ALU ops, EXE_B for BEQ/BNE, EXE_M for SW/LW.
  - EXE_R→WB_R→IF.
  - EXE_B→IF.
  - EXE_M→MEM. MEM→IF for SW, MEM→WB_L→IF for LW.
  - HLT holds until Reset.
- IRWre=1 only in IF.
- PCWre=1 only in each instruction's final state: ID (jumps/illegal), EXE_B, MEM (SW), WB_R, WB_L.
- RegWre=1 in WB_R, WB_L, and in ID for JAL. For JAL: RegDst=00, WrRegDSrc=0.
- PCSrc:
  - J/JAL → 11; JR → 10.
  - BEQ → 01 iff zero=1; BNE → 01 iff zero=0.
  - Everything else → 00, including illegal opcodes, which execute as a NOP.
- ALU operand selects:
  - ALUSrcB=1 for ADDIU/ORI/SW/LW.
  - ALUSrcA=1 for SLL.
  - ExtSel=0 only for ORI.
- mRD=1 in MEM for LW. mWR=1 in MEM for SW. DBDataSrc=1 in WB_L.
- BEQ/BNE use ALUOp sub.
- Selects are don't-care outside their active state but must be driven 0, never X.

## Timing
- State register updates on the rising CLK edge. All outputs are combinational from state, opcode and zero; zero only affects EXE_B.
- Latency in cycles: J/JR/JAL 2; BEQ/BNE 3; ALU ops 4; SW 4; LW 5.
- Reset:
  - Reset=0 forces state IF asynchronously.
  - While Reset=0, every enable and strobe (PCWre, IRWre, RegWre, mRD, mWR) is 0 and halted=0.
  - First IF occurs on the first edge after release.
- Reset mid-instruction abandons it; no partial register or memory write may occur after the asserting edge.

## Configuration
- `MCC_PERF_CNT_EN`, defined:
  - Adds outputs `cycle_cnt[31:0]` and `instr_cnt[31:0]`, both cleared by Reset.
  - `cycle_cnt` increments each cycle the FSM is not in HLT.
  - `instr_cnt` increments on each PCWre=1 cycle.
  - Both wrap at 2^32.
- Undefined: the ports and logic are absent.

## Structure
- `multi_cycle_pkg` holds opcode constants, the state enum, and the ALUOp and PCSrc/RegDst encodings.
- Sub-module `multi_cycle_decode` is purely combinational: (state, opcode, zero) → control outputs. The top holds only the state register and the optional counters.

## Test plan
- Reset held 30 ns, then ADD: state sequence IF, ID, EXE_R, WB_R; RegWre=1, RegDst=10 and PCWre=1 only in WB_R; 4 cycles.
- LW: mRD=1 in MEM, DBDataSrc=1 and RegWre=1 in WB_L; 5 cycles. SW: mWR=1 in MEM, PCWre=1 there; 4 cycles.
- BEQ with zero=1 → PCSrc=01. BEQ with zero=0 → PCSrc=00. BNE with zero=0 → PCSrc=01.
- JAL → ID has RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1. JR → PCSrc=10. Opcode 101010 → NOP, back to IF after 2 cycles.
- HALT → halted=1 and all enables 0 for 50 cycles. Reset pulse → IF, halted=0.
- Reset asserted in MEM of SW → mWR drops immediately. With `MCC_PERF_CNT_EN`, counters read 0 after reset and instr_cnt=3 after ADD, LW, J.
